dkong_uart_tx: RTL and testbench
================================

DKONG_UART_TX -- requirements
Module: dkong_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, meaning clock cycles per serial bit; legal values are 1 or greater.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit buffer entries; legal values are powers of 2, 2 or greater.
REQ-003 SHALL have port masterclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port tx_data, input, 8 bits: byte offered for transmission.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-007 SHALL have port tx_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-008 SHALL have port ser_out, output, 1 bit: serial line, idle high, 8N1.
REQ-009 SHALL have port tx_busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-011 SHALL accept a byte on a rising edge where tx_valid=1 and tx_ready=1, and only then; tx_data is ignored at all other times.
REQ-012 SHALL drive tx_ready = (fifo_level != FIFO_DEPTH), derived from the registered level only; it SHALL NOT depend combinationally on tx_valid.
REQ-013 SHALL make a push while full impossible: no push occurs when full, even if a pop occurs on the same edge.
REQ-014 SHALL complete a simultaneous push and pop on a non-empty, non-full FIFO with fifo_level unchanged and no data lost.
REQ-015 SHALL implement the transmit FSM with states IDLE, START, DATA, STOP.
REQ-016 SHALL behave in IDLE as follows: ser_out=1; if fifo_level>0 on an edge, pop the head into a shift register and go to START.
REQ-017 SHALL behave in START as follows: ser_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-018 SHALL behave in DATA as follows: 8 bits, LSB first, each held for exactly CLKS_PER_BIT cycles, with a 3-bit bit index; after bit 7, go to STOP.
REQ-019 SHALL behave in STOP as follows: ser_out=1 for CLKS_PER_BIT cycles; on the last STOP cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
REQ-020 SHALL make every frame exactly 10*CLKS_PER_BIT cycles long, and SHALL make back-to-back frames contiguous.
REQ-021 SHALL register ser_out so that it is glitch-free.
REQ-022 SHALL give a byte accepted on edge k into an empty FIFO, with the FSM in IDLE, a ser_out falling edge after edge k+1 (latency 2 edges).
REQ-023 SHALL use a bit-period counter of width $clog2(CLKS_PER_BIT+1) that wraps to 0 at CLKS_PER_BIT-1; with CLKS_PER_BIT=1 each bit lasts one cycle.
REQ-024 SHALL drive tx_busy = (state != IDLE) or (fifo_level != 0).
REQ-025 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-026 SHALL, on rst=1 at an edge, set the state to IDLE, ser_out=1, fifo_level=0, pointers=0, bit counters=0, tx_busy=0, tx_ready=1.
REQ-027 SHALL, on a reset mid-frame, abort the frame: ser_out=1 after that edge, FIFO contents discarded, no partial byte resumed.
REQ-028 SHALL ignore tx_valid while rst=1.

Structure
REQ-029 SHALL place the FSM state encodings and the frame constants (START/DATA/STOP bit counts, DATA_BITS=8) in the shared package dkong_uart_pkg, so the existing receiver can use them too.
REQ-030 SHALL instantiate the buffer as the sub-module dkong_sync_fifo (parameters WIDTH, DEPTH; push/pop/level), with the FSM and shifter in dkong_uart_tx.

Verification
REQ-031 SHALL verify a single byte: CLKS_PER_BIT=4, push 0xA5 into an empty FIFO -> ser_out low 2 edges after the push, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; 40-cycle frame; tx_busy falls after the frame.
REQ-032 SHALL verify back-to-back bytes: CLKS_PER_BIT=1, push 0x00, 0xFF, 0x55 on consecutive cycles -> 30 contiguous frame cycles with no idle bit between frames; fifo_level peaks at 2.
REQ-033 SHALL verify full: CLKS_PER_BIT=2, FIFO_DEPTH=8, hold tx_valid=1 for 20 cycles -> tx_ready=0 once level=8 (1 byte in the shifter); only 9 bytes accepted; transmitted order equals push order.
REQ-034 SHALL verify simultaneous push and pop: push exactly on the last STOP cycle with level=1 -> level stays 1 and the next frame starts immediately.
REQ-035 SHALL verify reset mid-frame: assert rst during DATA bit 3 with level=3 -> next cycle ser_out=1, level=0, tx_ready=1, tx_busy=0; no further frames.
REQ-036 SHALL verify the RX loopback: connect to the existing receiver with the same CLKS_PER_BIT, send 0x00 to 0xFF -> all 256 bytes received intact.

Source files
------------

// File: rtl/dkong_uart_pkg.sv
// Shared UART frame constants and FSM encodings for the dkong serial link.
// The receiver decodes the same frame shape, so both sides import these.
package dkong_uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int START_BITS = 1;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;

    typedef logic [DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/dkong_sync_fifo.sv
// Single-clock FIFO with occupancy output; push is refused when full and pop
// is refused when empty, so the caller never corrupts the pointers.
module dkong_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   masterclk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    // Full is judged on the registered level, so a same-edge pop never opens room.
    assign do_push = push && !full && !rst;
    assign do_pop  = pop && !empty && !rst;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge masterclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge masterclk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dkong_uart_tx.sv
// Buffered 8N1 UART transmitter: FIFO front end feeding a start/data/stop
// shifter with a registered, glitch-free serial output.
module dkong_uart_tx
    import dkong_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        masterclk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        ser_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_START = 3'(START_BITS - 1);
    localparam logic [2:0]    LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP  = 3'(STOP_BITS - 1);

    logic [1:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    uart_byte_t    shreg;
    uart_byte_t    head;
    logic          ser_q;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          period_end;
    logic          last_bit;

    dkong_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .masterclk (masterclk),
        .rst       (rst),
        .push      (tx_valid),
        .pop       (pop),
        .wr_data   (tx_data),
        .rd_data   (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_ready   = !fifo_full;
    assign tx_busy    = (state != ST_IDLE) || !fifo_empty;
    assign ser_out    = ser_q;
    assign period_end = (bit_cnt == CNT_LAST);

    always_comb begin
        last_bit = 1'b0;
        case (state)
            ST_START: last_bit = (bit_idx == LAST_START);
            ST_DATA:  last_bit = (bit_idx == LAST_DATA);
            ST_STOP:  last_bit = (bit_idx == LAST_STOP);
            default:  last_bit = 1'b0;
        endcase
    end

    // Popping on the final stop cycle chains the next start bit with no idle gap.
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) || (state == ST_STOP && period_end && last_bit));

    always_ff @(posedge masterclk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            ser_q   <= 1'b1;
        end else begin
            bit_cnt <= (state == ST_IDLE || period_end) ? '0 : bit_cnt + 1'b1;
            if (state == ST_IDLE)
                bit_idx <= '0;
            else if (period_end)
                bit_idx <= last_bit ? 3'd0 : bit_idx + 1'b1;

            case (state)
                ST_IDLE: begin
                    ser_q <= 1'b1;
                    if (pop) begin
                        shreg <= head;
                        state <= ST_START;
                        ser_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (period_end && last_bit) begin
                        state <= ST_DATA;
                        ser_q <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                ST_DATA: begin
                    if (period_end) begin
                        if (last_bit) begin
                            state <= ST_STOP;
                            ser_q <= 1'b1;
                        end else begin
                            ser_q <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end
                end
                ST_STOP: begin
                    if (period_end && last_bit) begin
                        if (pop) begin
                            shreg <= head;
                            state <= ST_START;
                            ser_q <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            ser_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ser_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dkong_uart_tx.sv
// Bench for dkong_uart_tx: three instances (4, 1 and 2 clocks per bit) with a
// frame-level line decoder and an ordered byte scoreboard per instance.
module tb_dkong_uart_tx;
    localparam int NI = 3;

    logic masterclk = 1'b0;
    always #5 masterclk = ~masterclk;

    logic [NI-1:0]      rst;
    logic [NI-1:0]      tx_valid;
    logic [NI-1:0][7:0] tx_data;
    wire  [NI-1:0]      tx_ready;
    wire  [NI-1:0]      ser_out;
    wire  [NI-1:0]      tx_busy;
    wire  [NI-1:0][3:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_cnt  [NI];
    int acc_cnt [NI];
    logic [7:0] exp_q  [NI][$];
    int         starts [NI][$];

    dkong_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) u_c4 (
        .masterclk(masterclk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .ser_out(ser_out[0]), .tx_busy(tx_busy[0]), .fifo_level(fifo_level[0]));
    dkong_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(8)) u_c1 (
        .masterclk(masterclk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .ser_out(ser_out[1]), .tx_busy(tx_busy[1]), .fifo_level(fifo_level[1]));
    dkong_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(8)) u_c2 (
        .masterclk(masterclk), .rst(rst[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .ser_out(ser_out[2]), .tx_busy(tx_busy[2]), .fifo_level(fifo_level[2]));

    function automatic int cpb(input int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge masterclk);
        #2;
    endtask

    always @(posedge masterclk) cyc <= cyc + 1;

    // Handshake scoreboard: every accepted byte must later appear on the line in order.
    always @(posedge masterclk) begin
        for (int g = 0; g < NI; g++) begin
            if (rst[g]) exp_q[g].delete();
            else if (tx_valid[g] && tx_ready[g]) begin
                exp_q[g].push_back(tx_data[g]);
                acc_cnt[g] <= acc_cnt[g] + 1;
            end
        end
    end

    // Line decoder: a frame is C low samples, 8 data periods of C equal samples, C high samples.
    task automatic monitor(input int g);
        int c;
        int st;
        logic [7:0] b;
        logic want;
        bit bad;
        bit ab;
        c = cpb(g);
        forever begin
            @(negedge masterclk);
            if (ser_out[g] === 1'b0 && !rst[g]) begin
                st = cyc; bad = 1'b0; ab = 1'b0; b = '0;
                for (int k = 0; k < 10*c; k++) begin
                    if (k > 0) @(negedge masterclk);
                    if (rst[g]) begin ab = 1'b1; break; end
                    if (k < c) want = 1'b0;
                    else if (k >= 9*c) want = 1'b1;
                    else begin
                        if ((k - c) % c == 0) b[(k - c) / c] = ser_out[g];
                        want = b[(k - c) / c];
                    end
                    if (ser_out[g] !== want) bad = 1'b1;
                end
                if (!ab) begin
                    chk($sformatf("frame_fmt%0d", g), 32'(bad), 32'd0);
                    if (exp_q[g].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rx_unexpected%0d: got byte %0h expected none (cycle %0d)", g, b, cyc);
                    end else
                        chk($sformatf("rx_byte%0d", g), b, exp_q[g].pop_front());
                    starts[g].push_back(st);
                    rx_cnt[g]++;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic drain(input int g, input int budget);
        int t;
        t = 0;
        @(negedge masterclk);
        while ((exp_q[g].size() != 0 || tx_busy[g] !== 1'b0) && t < budget) begin
            @(negedge masterclk);
            t++;
        end
        chk($sformatf("drain%0d_left", g), exp_q[g].size(), 0);
        chk($sformatf("drain%0d_busy", g), tx_busy[g], 1'b0);
        step(1);
    endtask

    typedef struct {
        int         n;
        logic       ser;
        logic       busy;
        logic [3:0] lvl;
    } vec_t;
    vec_t tbl[$];

    function automatic void add_v(input int n, input logic s, input logic b, input logic [3:0] l);
        vec_t v;
        v.n = n; v.ser = s; v.busy = b; v.lvl = l;
        tbl.push_back(v);
    endfunction

    initial begin
        int idx, k, s0, peak, lows, base, exp_lvl, cnt, t;
        bit acc;

        // 0xA5 at 4 clocks/bit, sampled n edges after the accepting edge.
        add_v(0, 1, 1, 1);  add_v(1, 0, 1, 0);  add_v(4, 0, 1, 0);  add_v(5, 1, 1, 0);
        add_v(8, 1, 1, 0);  add_v(9, 0, 1, 0);  add_v(13, 1, 1, 0); add_v(17, 0, 1, 0);
        add_v(20, 0, 1, 0); add_v(21, 0, 1, 0); add_v(25, 1, 1, 0); add_v(29, 0, 1, 0);
        add_v(33, 1, 1, 0); add_v(36, 1, 1, 0); add_v(37, 1, 1, 0); add_v(40, 1, 1, 0);
        add_v(41, 1, 0, 0);

        rst = '1; tx_valid = '0; tx_data = '0;
        step(3);
        tx_valid = '1;
        @(negedge masterclk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_ser%0d", g), ser_out[g], 1'b1);
            chk($sformatf("rst_level%0d", g), fifo_level[g], 4'd0);
            chk($sformatf("rst_ready%0d", g), tx_ready[g], 1'b1);
            chk($sformatf("rst_busy%0d", g), tx_busy[g], 1'b0);
        end
        step(1);
        chk("rst_ignores_valid", fifo_level[0], 4'd0);
        tx_valid = '0; rst = '0;
        step(2);

        // Single byte, table driven.
        tx_data[0] = 8'hA5; tx_valid[0] = 1'b1;
        step(1);
        tx_valid[0] = 1'b0;
        idx = 0;
        for (int n = 0; n <= 41; n++) begin
            @(negedge masterclk);
            if (idx < tbl.size() && tbl[idx].n == n) begin
                chk($sformatf("a5_ser_n%0d", n), ser_out[0], tbl[idx].ser);
                chk($sformatf("a5_busy_n%0d", n), tx_busy[0], tbl[idx].busy);
                chk($sformatf("a5_lvl_n%0d", n), fifo_level[0], tbl[idx].lvl);
                idx++;
            end
        end
        step(1);

        // Back-to-back frames at 1 clock/bit.
        s0 = starts[1].size(); peak = 0; k = 0;
        for (int i = 0; i < 3; i++) begin
            tx_valid[1] = 1'b1;
            tx_data[1] = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h55;
            step(1);
            if (i == 0) k = cyc;
            @(negedge masterclk);
            if (int'(fifo_level[1]) > peak) peak = int'(fifo_level[1]);
        end
        tx_valid[1] = 1'b0;
        repeat (40) begin
            @(negedge masterclk);
            if (int'(fifo_level[1]) > peak) peak = int'(fifo_level[1]);
        end
        chk("b2b_peak", peak, 2);
        chk("b2b_frames", starts[1].size() - s0, 3);
        if (starts[1].size() >= s0 + 3) begin
            chk("b2b_start0", starts[1][s0], k + 1);
            chk("b2b_start1", starts[1][s0+1], k + 11);
            chk("b2b_start2", starts[1][s0+2], k + 21);
        end
        chk("b2b_busy_end", tx_busy[1], 1'b0);
        step(1);

        // Hold valid for 20 cycles into a depth-8 FIFO at 2 clocks/bit.
        base = acc_cnt[2];
        for (int i = 0; i < 20; i++) begin
            tx_valid[2] = 1'b1; tx_data[2] = 8'($urandom);
            step(1);
            @(negedge masterclk);
            exp_lvl = (i == 0) ? 1 : (i > 8 ? 8 : i);
            chk($sformatf("full_level_e%0d", i), fifo_level[2], exp_lvl);
            chk($sformatf("full_ready_e%0d", i), tx_ready[2], 32'(exp_lvl != 8));
        end
        tx_valid[2] = 1'b0;
        chk("full_accepted", acc_cnt[2] - base, 9);
        drain(2, 400);

        // Push exactly on the last stop cycle while one byte is queued.
        s0 = starts[2].size();
        tx_valid[2] = 1'b1; tx_data[2] = 8'h3C;
        step(1);
        k = cyc; tx_valid[2] = 1'b0;
        step(4);
        tx_valid[2] = 1'b1; tx_data[2] = 8'hC3;
        step(1);
        tx_valid[2] = 1'b0;
        step(15);
        tx_valid[2] = 1'b1; tx_data[2] = 8'h81;
        @(negedge masterclk);
        chk("pp_pre_level", fifo_level[2], 4'd1);
        chk("pp_pre_ser", ser_out[2], 1'b1);
        step(1);
        tx_valid[2] = 1'b0;
        @(negedge masterclk);
        chk("pp_level", fifo_level[2], 4'd1);
        chk("pp_ser_start", ser_out[2], 1'b0);
        drain(2, 200);
        chk("pp_frames", starts[2].size() - s0, 3);
        if (starts[2].size() >= s0 + 3) begin
            chk("pp_gap1", starts[2][s0+1] - starts[2][s0], 20);
            chk("pp_gap2", starts[2][s0+2] - starts[2][s0+1], 20);
            chk("pp_first", starts[2][s0], k + 1);
        end

        // Reset during data bit 3 with three bytes queued.
        s0 = rx_cnt[0]; k = 0;
        for (int i = 0; i < 4; i++) begin
            tx_valid[0] = 1'b1;
            tx_data[0] = (i == 0) ? 8'h37 : 8'($urandom);
            step(1);
            if (i == 0) k = cyc;
        end
        tx_valid[0] = 1'b0;
        step(14);
        @(negedge masterclk);
        chk("rst_pre_level", fifo_level[0], 4'd3);
        chk("rst_pre_ser", ser_out[0], 1'b0);
        rst[0] = 1'b1;
        step(1);
        @(negedge masterclk);
        chk("midrst_ser", ser_out[0], 1'b1);
        chk("midrst_level", fifo_level[0], 4'd0);
        chk("midrst_ready", tx_ready[0], 1'b1);
        chk("midrst_busy", tx_busy[0], 1'b0);
        step(1);
        rst[0] = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge masterclk);
            if (ser_out[0] !== 1'b1) lows++;
        end
        chk("midrst_quiet_line", lows, 0);
        chk("midrst_no_frames", rx_cnt[0] - s0, 0);
        step(1);

        // Loopback of every byte value with random valid gaps.
        s0 = rx_cnt[1]; cnt = 0; t = 0;
        while (cnt < 256 && t < 6000) begin
            tx_data[1] = 8'(cnt);
            tx_valid[1] = ($urandom_range(0, 3) != 0);
            @(negedge masterclk);
            acc = tx_valid[1] && tx_ready[1];
            step(1);
            if (acc) cnt++;
            t++;
        end
        tx_valid[1] = 1'b0;
        chk("loop_sent", cnt, 256);
        drain(1, 400);
        chk("loop_rx", rx_cnt[1] - s0, 256);

        // Random bytes with random gaps at 4 clocks/bit.
        s0 = rx_cnt[0]; cnt = 0; t = 0;
        while (cnt < 20 && t < 3000) begin
            tx_data[0] = 8'($urandom);
            tx_valid[0] = ($urandom_range(0, 1) != 0);
            @(negedge masterclk);
            acc = tx_valid[0] && tx_ready[0];
            step(1);
            if (acc) cnt++;
            t++;
        end
        tx_valid[0] = 1'b0;
        drain(0, 1200);
        chk("rand_rx", rx_cnt[0] - s0, cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
